// File: rtl/coffee_dispense_ctrl.sv
// Coffee dispense controller: grind, brew (pausable on cup removal), done and error handling.
// Latency: start sampled in IDLE -> GRIND next edge; GRIND_CYC grind cycles, BREW_BASE*(k+1) valve-open cycles.
// Backpressure: none; cup withdrawal freezes brewing (PAUSE), too long a pause abandons the order to ERROR.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start, i_sel        order request and one-hot drink selection (sampled only in IDLE)
//   i_cup, i_clear        cup-present sensor, error acknowledge
//   o_valve, o_grinder    actuators (valve only in BREW, grinder only in GRIND)
//   o_ready, o_paused     IDLE / PAUSE indicators
//   o_done                one-cycle pulse on BREW->DONE
//   o_err_sel, o_err_cup  latched error flags, cleared by i_clear
module coffee_dispense_ctrl #(
  parameter int N_SEL     = 3,
  parameter int CNT_W     = 8,
  parameter int GRIND_CYC = 4,
  parameter int BREW_BASE = 8,
  parameter int PAUSE_MAX = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [N_SEL-1:0] i_sel,
  input  logic             i_cup,
  input  logic             i_clear,
  output logic [N_SEL-1:0] o_valve,
  output logic             o_grinder,
  output logic             o_ready,
  output logic             o_paused,
  output logic             o_done,
  output logic             o_err_sel,
  output logic             o_err_cup
);

  // Reject configurations whose counts cannot be held in CNT_W bits.
  generate
    if (N_SEL < 1 || GRIND_CYC < 1 || BREW_BASE < 1 || PAUSE_MAX < 1 ||
        longint'(BREW_BASE) * longint'(N_SEL) >= (longint'(1) << CNT_W) ||
        longint'(GRIND_CYC) >= (longint'(1) << CNT_W) ||
        longint'(PAUSE_MAX) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
      $error("coffee_dispense_ctrl: counts do not fit in CNT_W bits");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRIND,
    S_BREW,
    S_PAUSE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] GRIND_LEN  = CNT_W'(GRIND_CYC);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;    // grind / brew cycles remaining
  logic [CNT_W-1:0] r_pcnt;   // consecutive cup-absent cycles spent in PAUSE
  logic [N_SEL-1:0] r_sel;    // channel latched for the current order
  logic             r_done;
  logic             r_err_sel;
  logic             r_err_cup;

  logic             w_sel_ok;
  logic [CNT_W-1:0] w_brew_len;

  assign w_sel_ok = $onehot(i_sel);

  // Brew length of the latched channel; r_sel is one-hot so OR-ing the terms selects one.
  always_comb begin
    w_brew_len = '0;
    for (int i = 0; i < N_SEL; i++) begin
      if (r_sel[i]) begin
        w_brew_len = w_brew_len | CNT_W'(BREW_BASE * (i + 1));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pcnt    <= '0;
      r_sel     <= '0;
      r_done    <= 1'b0;
      r_err_sel <= 1'b0;
      r_err_cup <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (!w_sel_ok || !i_cup) begin
              r_err_sel <= !w_sel_ok;
              r_err_cup <= !i_cup;
              r_state   <= S_ERROR;
            end else begin
              r_sel   <= i_sel;
              r_cnt   <= GRIND_LEN;
              r_state <= S_GRIND;
            end
          end
        end
        S_GRIND: begin
          // Grinding ignores the cup; it is only checked when the valve would open.
          if (r_cnt == CNT_ONE) begin
            r_cnt   <= w_brew_len;
            r_pcnt  <= '0;
            r_state <= i_cup ? S_BREW : S_PAUSE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_BREW: begin
          // Every cycle spent in BREW had the valve open, so it is counted even when
          // the cup disappears during it; that keeps total valve-open time exact.
          if (r_cnt == CNT_ONE) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
            if (!i_cup) begin
              r_pcnt  <= '0;
              r_state <= S_PAUSE;
            end
          end
        end
        S_PAUSE: begin
          if (i_cup) begin
            r_state <= S_BREW;
          end else if (r_pcnt == PAUSE_LAST) begin
            r_err_cup <= 1'b1;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_state   <= S_ERROR;
          end else begin
            r_pcnt <= r_pcnt + CNT_ONE;
          end
        end
        S_DONE: begin
          if (!i_cup) begin
            r_sel   <= '0;
            r_state <= S_IDLE;
          end
        end
        S_ERROR: begin
          if (i_clear) begin
            r_err_sel <= 1'b0;
            r_err_cup <= 1'b0;
            r_sel     <= '0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_valve   = (r_state == S_BREW) ? r_sel : '0;
  assign o_grinder = (r_state == S_GRIND);
  assign o_ready   = (r_state == S_IDLE);
  assign o_paused  = (r_state == S_PAUSE);
  assign o_done    = r_done;
  assign o_err_sel = r_err_sel;
  assign o_err_cup = r_err_cup;

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// Directed bench for coffee_dispense_ctrl: default instance plus N_SEL=5/BREW_BASE=2 instance.
// Latency: inputs change #1 after a rising edge, outputs sampled at the same point.
// Backpressure: not applicable; all loops run for a fixed number of cycles.
module tb_coffee_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cup, clear;
  logic [2:0] sel;
  logic [2:0] valve;
  logic       grinder, ready, paused, done, err_sel, err_cup;

  logic       d5_start, d5_cup, d5_clear;
  logic [4:0] d5_sel, d5_valve;
  logic       d5_grinder, d5_ready, d5_paused, d5_done, d5_err_sel, d5_err_cup;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  coffee_dispense_ctrl u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sel(sel), .i_cup(cup),
    .i_clear(clear), .o_valve(valve), .o_grinder(grinder), .o_ready(ready),
    .o_paused(paused), .o_done(done), .o_err_sel(err_sel), .o_err_cup(err_cup)
  );

  coffee_dispense_ctrl #(.N_SEL(5), .BREW_BASE(2)) u_dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(d5_start), .i_sel(d5_sel), .i_cup(d5_cup),
    .i_clear(d5_clear), .o_valve(d5_valve), .o_grinder(d5_grinder), .o_ready(d5_ready),
    .o_paused(d5_paused), .o_done(d5_done), .o_err_sel(d5_err_sel), .o_err_cup(d5_err_cup)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues a start pulse, then samples n cycles (index 0 = first edge after start).
  // Cup drops after sample off_i and returns after sample on_i; sel is scrambled mid-order.
  task automatic run(input int n, input int off_i, input int on_i, input logic [2:0] vsel,
                     output int g, output int v, output int bad, output int p,
                     output int d, output int d_idx, output int pv);
    g = 0; v = 0; bad = 0; p = 0; d = 0; d_idx = -1; pv = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (grinder) g++;
      if (valve == vsel) v++;
      else if (valve != 3'b000) bad++;
      if (paused) p++;
      if (paused && valve != 3'b000) pv++;
      if (done) begin d++; d_idx = i; end
      if (i == off_i) cup = 1'b0;
      if (i == on_i) cup = 1'b1;
      if (i == 2) sel = 3'b111;
      if (i < n - 1) tick();
    end
  endtask

  int g, v, bad, p, d, d_idx, pv;

  initial begin
    rst_n = 1'b1; start = 1'b0; cup = 1'b0; clear = 1'b0; sel = 3'b000;
    d5_start = 1'b0; d5_cup = 1'b0; d5_clear = 1'b0; d5_sel = 5'b00000;
    #1 rst_n = 1'b0;
    #2;
    // Reset state, before any clock edge.
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_valve", {29'b0, valve}, 32'd0);
    chk("rst_grinder", {31'b0, grinder}, 32'd0);
    chk("rst_flags", {28'b0, paused, done, err_sel, err_cup}, 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // Normal order, channel 1: 4 grind, 16 valve cycles, single done pulse.
    cup = 1'b1; sel = 3'b010;
    run(25, -1, -1, 3'b010, g, v, bad, p, d, d_idx, pv);
    chk("norm_grind_cycles", g, 32'd4);
    chk("norm_valve_cycles", v, 32'd16);
    chk("norm_bad_valve", bad, 32'd0);
    chk("norm_done_count", d, 32'd1);
    chk("norm_done_index", d_idx, 32'd20);
    chk("norm_hold_done", {31'b0, ready}, 32'd0);
    sel = 3'b001; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_ignores_start", {30'b0, ready, grinder}, 32'd0);
    cup = 1'b0;
    tick();
    chk("done_to_idle", {31'b0, ready}, 32'd1);

    // Invalid selection with cup present.
    cup = 1'b1; sel = 3'b011; start = 1'b1;
    tick();
    chk("bad_sel_errs", {30'b0, err_sel, err_cup}, 32'd2);
    chk("bad_sel_act", {27'b0, valve, grinder, ready}, 32'd0);
    sel = 3'b001;
    tick();
    tick();
    start = 1'b0;
    chk("err_ignores_start", {29'b0, ready, grinder, err_sel}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_to_idle", {29'b0, ready, err_sel, err_cup}, 32'd4);

    // Invalid selection and no cup together set both flags; valid sel without cup sets one.
    cup = 1'b0; sel = 3'b000; start = 1'b1;
    tick();
    start = 1'b0;
    chk("both_errs", {30'b0, err_sel, err_cup}, 32'd3);
    clear = 1'b1; tick(); clear = 1'b0;
    sel = 3'b100; start = 1'b1;
    tick();
    start = 1'b0;
    chk("no_cup_err", {30'b0, err_sel, err_cup}, 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("no_cup_cleared", {29'b0, ready, err_sel, err_cup}, 32'd4);

    // Pause during brew: channel 0, cup gone for 5 cycles from brew cycle 3.
    cup = 1'b1; sel = 3'b001;
    run(25, 6, 11, 3'b001, g, v, bad, p, d, d_idx, pv);
    chk("pause_valve_cycles", v, 32'd8);
    chk("pause_paused_cycles", p, 32'd5);
    chk("pause_valve_in_pause", pv, 32'd0);
    chk("pause_done_index", d_idx, 32'd17);
    chk("pause_done_count", d, 32'd1);
    cup = 1'b0; tick();
    chk("pause_back_idle", {31'b0, ready}, 32'd1);

    // Cup removed during grind: grinding continues, then pause until cup returns.
    cup = 1'b1; sel = 3'b001;
    run(16, 0, 4, 3'b001, g, v, bad, p, d, d_idx, pv);
    chk("grind_cupless_grind", g, 32'd4);
    chk("grind_cupless_paused", p, 32'd1);
    chk("grind_cupless_valve", v, 32'd8);
    chk("grind_cupless_done", d_idx, 32'd13);
    cup = 1'b0; tick();

    // Pause timeout: 16 cup-absent cycles in PAUSE -> ERROR with err_cup.
    cup = 1'b1; sel = 3'b100;
    run(22, 4, -1, 3'b100, g, v, bad, p, d, d_idx, pv);
    chk("tmo_paused_cycles", p, 32'd16);
    chk("tmo_valve_cycles", v, 32'd1);
    chk("tmo_no_done", d, 32'd0);
    chk("tmo_errs", {29'b0, paused, err_sel, err_cup}, 32'd1);
    cup = 1'b1; sel = 3'b001; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("tmo_start_ignored", {27'b0, valve, grinder, ready}, 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("tmo_cleared", {30'b0, ready, err_cup}, 32'd2);

    // Asynchronous reset in the middle of BREW.
    sel = 3'b010; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("mid_brew_valve", {29'b0, valve}, 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {26'b0, valve, grinder, ready, done}, 32'd2);
    d = 0;
    repeat (3) begin tick(); if (done) d++; end
    #3 rst_n = 1'b1;
    tick();
    if (done) d++;
    chk("rst_no_done", d, 32'd0);
    chk("rst_resume_idle", {31'b0, ready}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("rst_resume_grind", {30'b0, grinder, ready}, 32'd2);

    // Wide instance: channel 4 brews 2*5 = 10 cycles.
    d5_cup = 1'b1; d5_sel = 5'b10000; d5_start = 1'b1;
    tick();
    d5_start = 1'b0;
    v = 0; d = 0; d_idx = -1; bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (d5_valve == 5'b10000) v++;
      else if (d5_valve != 5'b00000) bad++;
      if (d5_done) begin d++; d_idx = i; end
      if (i < 19) tick();
    end
    chk("w5_valve_cycles", v, 32'd10);
    chk("w5_bad_valve", bad, 32'd0);
    chk("w5_done_index", d_idx, 32'd14);
    chk("w5_done_count", d, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
